fetch_stage: RTL and testbench

//   IF stage of the 5-stage pipeline. Owns the PC and drives the byte address into the

---
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches from combinational imem into the IF/ID register, handles redirect bubbles and halt drain.
// Latency: word at pc lands on ifid_* one edge later; stall holds everything; redirect wins over stall and inserts a bubble.
module fetch_stage #(
  parameter int                WORD_W       = 32,
  parameter logic [WORD_W-1:0] RESET_PC     = '0,
  parameter logic [WORD_W-1:0] HALT_WORD    = '1,
  parameter int                DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic              halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, HALTING, HALTED} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] pc_plus4;

  assign pc_plus4 = pc_q + WORD_W'(4);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = imem_data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          // The halt word itself still goes to decode; fetch parks on it.
          if (imem_data == HALT_WORD) begin
            cnt_d   = '0;
            state_d = HALTING;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      HALTING: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else if (!stall) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a byte-addressed little-endian imem model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_data, pc, ifid_instr, ifid_pc4;
  logic        ifid_valid, halted;
  logic [7:0]  mem [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [31:0] WA = 32'hAAAA0001, WB = 32'hBBBB0002, WC = 32'hCCCC0003;
  localparam logic [31:0] WD = 32'hDDDD0004, WE = 32'hEEEE0020, HALT = 32'hFFFFFFFF;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .halted(halted)
  );

  always_comb begin
    logic [7:0] a;
    a = imem_addr[7:0];
    imem_data = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [7:0] addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[addr + 8'(i)] = w[8*i +: 8];
  endtask

  task automatic do_reset;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h1234;
    tick;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, 32'h0); end
    n_checks++; if ({ifid_instr, ifid_pc4, ifid_valid} !== 65'h0) begin n_fail++;
      $display("FAIL reset_ifid: got %h/%h/%b want 0/0/0", ifid_instr, ifid_pc4, ifid_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_w [3];
    exp_w[0] = WA; exp_w[1] = WB; exp_w[2] = WC;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if ({ifid_instr, ifid_pc4, ifid_valid} !== {exp_w[i], 32'(4*(i+1)), 1'b1}) begin n_fail++;
        $display("FAIL seq_ifid[%0d]: got %h/%h/%b want %h/%h/1", i, ifid_instr, ifid_pc4, ifid_valid, exp_w[i], 4*(i+1)); end
      n_checks++; if (pc !== 32'(4*(i+1))) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 4*(i+1)); end
    end
  endtask

  task automatic test_stall;
    do_reset;
    tick; tick;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_checks++; if ({ifid_instr, ifid_pc4, ifid_valid} !== {WB, 32'h8, 1'b1}) begin n_fail++;
        $display("FAIL stall_ifid[%0d]: got %h/%h/%b want %h/8/1", i, ifid_instr, ifid_pc4, ifid_valid, WB); end
      n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 8", i, pc); end
    end
    stall = 1'b0;
    tick;
    n_checks++; if ({ifid_instr, ifid_pc4, ifid_valid} !== {WC, 32'hC, 1'b1}) begin n_fail++;
      $display("FAIL stall_release: got %h/%h/%b want %h/c/1", ifid_instr, ifid_pc4, ifid_valid, WC); end
  endtask

  task automatic test_redirect;
    do_reset;
    redirect = 1'b1; redirect_pc = 32'h41; stall = 1'b1;
    tick;
    redirect = 1'b0; stall = 1'b0;
    n_checks++; if (pc !== 32'h41) begin n_fail++; $display("FAIL redir_pc: got %h want 41", pc); end
    n_checks++; if (imem_addr !== 32'h41) begin n_fail++; $display("FAIL redir_imem_addr: got %h want 41", imem_addr); end
    n_checks++; if ({ifid_instr, ifid_pc4, ifid_valid} !== 65'h0) begin n_fail++;
      $display("FAIL redir_bubble: got %h/%h/%b want 0/0/0", ifid_instr, ifid_pc4, ifid_valid); end
    tick;
    n_checks++; if ({ifid_instr, ifid_pc4, ifid_valid} !== {32'h44434241, 32'h45, 1'b1}) begin n_fail++;
      $display("FAIL redir_unaligned: got %h/%h/%b want 44434241/45/1", ifid_instr, ifid_pc4, ifid_valid); end
    n_checks++; if (pc !== 32'h45) begin n_fail++; $display("FAIL redir_pc_next: got %h want 45", pc); end
  endtask

  task automatic test_halt_drain;
    put_word(8'h0C, HALT);
    do_reset;
    tick; tick; tick; tick;
    n_checks++; if ({ifid_instr, ifid_pc4, ifid_valid} !== {HALT, 32'h10, 1'b1}) begin n_fail++;
      $display("FAIL halt_word: got %h/%h/%b want ffffffff/10/1", ifid_instr, ifid_pc4, ifid_valid); end
    n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL halt_pc: got %h want c", pc); end
    tick; tick;
    n_checks++; if ({halted, ifid_valid} !== 2'b00) begin n_fail++;
      $display("FAIL drain_b2: got halted=%b valid=%b want 0/0", halted, ifid_valid); end
    stall = 1'b1;
    tick;
    stall = 1'b0;
    tick;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL drain_stall_delay: got %b want 0", halted); end
    tick;
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL drain_done: got %b want 1", halted); end
    n_checks++; if ({pc, ifid_valid} !== {32'hC, 1'b0}) begin n_fail++;
      $display("FAIL drain_hold: got pc=%h valid=%b want c/0", pc, ifid_valid); end
    redirect = 1'b1; redirect_pc = 32'h20;
    tick;
    redirect = 1'b0;
    n_checks++; if ({pc, ifid_valid, halted} !== {32'hC, 1'b0, 1'b1}) begin n_fail++;
      $display("FAIL halted_ignores_redirect: got pc=%h valid=%b halted=%b want c/0/1", pc, ifid_valid, halted); end
  endtask

  task automatic test_halt_cancel;
    do_reset;
    tick; tick; tick; tick;
    tick;
    redirect = 1'b1; redirect_pc = 32'h20;
    tick;
    redirect = 1'b0;
    n_checks++; if ({pc, ifid_valid, halted} !== {32'h20, 1'b0, 1'b0}) begin n_fail++;
      $display("FAIL cancel_redirect: got pc=%h valid=%b halted=%b want 20/0/0", pc, ifid_valid, halted); end
    tick;
    n_checks++; if ({ifid_instr, ifid_pc4, ifid_valid} !== {WE, 32'h24, 1'b1}) begin n_fail++;
      $display("FAIL cancel_fetch: got %h/%h/%b want %h/24/1", ifid_instr, ifid_pc4, ifid_valid, WE); end
    for (int i = 0; i < 5; i++) tick;
    n_checks++; if ({halted, ifid_valid, pc} !== {1'b0, 1'b1, 32'h38}) begin n_fail++;
      $display("FAIL cancel_running: got halted=%b valid=%b pc=%h want 0/1/38", halted, ifid_valid, pc); end
  endtask

  task automatic test_wrap_and_rst;
    do_reset;
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    tick;
    redirect = 1'b0;
    tick;
    n_checks++; if ({ifid_instr, ifid_pc4, ifid_valid} !== {32'hFFFEFDFC, 32'h0, 1'b1}) begin n_fail++;
      $display("FAIL wrap_ifid: got %h/%h/%b want fffefdfc/0/1", ifid_instr, ifid_pc4, ifid_valid); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", pc); end
    tick; tick; tick; tick;
    tick;
    rst = 1'b1;
    tick;
    n_checks++; if ({pc, ifid_instr, ifid_pc4, ifid_valid, halted} !== 98'h0) begin n_fail++;
      $display("FAIL rst_mid_halting: got pc=%h %h/%h/%b halted=%b want all 0", pc, ifid_instr, ifid_pc4, ifid_valid, halted); end
    rst = 1'b0;
    tick;
    n_checks++; if ({ifid_instr, ifid_pc4, ifid_valid} !== {WA, 32'h4, 1'b1}) begin n_fail++;
      $display("FAIL rst_resume: got %h/%h/%b want %h/4/1", ifid_instr, ifid_pc4, ifid_valid, WA); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    put_word(8'h00, WA); put_word(8'h04, WB); put_word(8'h08, WC);
    put_word(8'h0C, WD); put_word(8'h20, WE);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset;
    test_sequential;
    test_stall;
    test_redirect;
    test_halt_drain;
    test_halt_cancel;
    test_wrap_and_rst;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
